// File: rtl/dcnt_pkg.sv
// ============================================================================
// Module   : dcnt_pkg
// Purpose  : Shared types and constants for the down-counter controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcnt_pkg;

  // Default counter width in bits
  localparam int c_default_width = 4;

  // Controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } dcnt_state_t;

endpackage : dcnt_pkg

`default_nettype wire

// File: rtl/dcnt_core.sv
// ============================================================================
// Module   : dcnt_core
// Purpose  : WIDTH-bit down-counter register. Clear has priority over load,
//            load has priority over decrement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcnt_core
  import dcnt_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rest_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Count register: clear, load or decrement
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_data;
    end else if (dec) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign cnt = r_cnt;

endmodule : dcnt_core

`default_nettype wire

// File: rtl/dcnt_ctrl.sv
// ============================================================================
// Module   : dcnt_ctrl
// Purpose  : Sequencing controller for the down-counter: start handshake,
//            pause, abort, terminal-count pulse and zero-load rejection.
//            Build option DCNT_AUTORELOAD_EN enables periodic auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcnt_ctrl
  import dcnt_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rest_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  input  logic             reload_en,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             load_err
);

  dcnt_state_t      r_state;
  dcnt_state_t      w_next;
  logic             r_load_err;
  logic             w_clr;
  logic             w_load;
  logic             w_dec;
  logic             w_rej;
  logic [WIDTH-1:0] w_load_data;

`ifdef DCNT_AUTORELOAD_EN
  logic [WIDTH-1:0] r_reload;
`else
  logic             w_unused_reload_en;
  assign w_unused_reload_en = reload_en;
`endif

  // Next-state and counter-control decode; abort wins over pause and terminal count
  always_comb begin
    w_next      = r_state;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_rej       = 1'b0;
    w_load_data = load_val;
    case (r_state)
      IDLE: begin
        if (start_valid) begin
          if (load_val != '0) begin
            w_load = 1'b1;
            w_next = RUN;
          end else begin
            w_rej = 1'b1;
          end
        end
      end
      RUN, PAUSE: begin
        // Leaving PAUSE decrements on the same edge so a pause costs only its own cycles
        if (abort) begin
          w_clr  = 1'b1;
          w_next = IDLE;
        end else if (pause) begin
          w_next = PAUSE;
        end else begin
          w_dec  = 1'b1;
          w_next = (cnt == WIDTH'(1)) ? DONE : RUN;
        end
      end
      DONE: begin
        if (abort) begin
          w_clr  = 1'b1;
          w_next = IDLE;
        end else begin
`ifdef DCNT_AUTORELOAD_EN
          if (reload_en) begin
            w_load      = 1'b1;
            w_load_data = r_reload;
            w_next      = RUN;
          end else begin
            w_next = IDLE;
          end
`else
          w_next = IDLE;
`endif
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register and registered zero-load error pulse
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_state    <= IDLE;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_load_err <= w_rej;
    end
  end

`ifdef DCNT_AUTORELOAD_EN
  // Reload value captured on every accepted start
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_reload <= '0;
    end else if (r_state == IDLE && start_valid && load_val != '0) begin
      r_reload <= load_val;
    end
  end
`endif

  dcnt_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rest_n    (rest_n),
    .clr       (w_clr),
    .load      (w_load),
    .load_data (w_load_data),
    .dec       (w_dec),
    .cnt       (cnt)
  );

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state == RUN) || (r_state == PAUSE);
  assign done        = (r_state == DONE);
  assign load_err    = r_load_err;

endmodule : dcnt_ctrl

`default_nettype wire

// File: tb/tb_dcnt_ctrl.sv
// ============================================================================
// Module   : tb_dcnt_ctrl
// Purpose  : Directed self-checking bench for dcnt_ctrl (WIDTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcnt_ctrl;

  logic       clk = 1'b0;
  logic       rest_n;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] load_val;
  logic       pause;
  logic       abort;
  logic       reload_en;
  logic [3:0] cnt;
  logic       busy;
  logic       done;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcnt_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rest_n      (rest_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .load_val    (load_val),
    .pause       (pause),
    .abort       (abort),
    .reload_en   (reload_en),
    .cnt         (cnt),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err)
  );

  // Advance one cycle; outputs settle 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output vector check against hand-computed values
  task automatic chk(input string name, input logic [3:0] e_cnt, input logic e_busy,
                     input logic e_done, input logic e_ready, input logic e_err);
    n_checks++;
    if (cnt !== e_cnt || busy !== e_busy || done !== e_done ||
        start_ready !== e_ready || load_err !== e_err) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d busy=%b done=%b ready=%b err=%b, expected cnt=%0d busy=%b done=%b ready=%b err=%b",
               name, cnt, busy, done, start_ready, load_err, e_cnt, e_busy, e_done, e_ready, e_err);
    end
  endtask

  task automatic start(input logic [3:0] v);
    start_valid = 1'b1;
    load_val    = v;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic test_reset();
    rest_n = 1'b0; start_valid = 1'b0; load_val = '0;
    pause = 1'b0; abort = 1'b0; reload_en = 1'b0;
    tick(); tick();
    chk("reset_initial", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rest_n = 1'b1;
    tick();
    start(4'd9);
    chk("reset_run_start", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    // Assert reset asynchronously mid-cycle while cnt = 9
    rest_n = 1'b0;
    #1;
    chk("reset_async_midrun", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    rest_n = 1'b1;
    tick();
    chk("reset_after_release", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_count();
    start(4'd5);
    chk("count_load5", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk($sformatf("count_step%0d", i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk("count_done", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("count_after_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_pause();
    int cycles;
    start(4'd6);
    tick(); tick();
    chk("pause_at4", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    pause  = 1'b1;
    cycles = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); cycles++;
      chk($sformatf("pause_hold%0d", i), 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    pause = 1'b0;
    tick(); cycles++;
    chk("pause_resume3", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    while (!done && cycles < 20) begin
      tick(); cycles++;
    end
    // Unpaused, done follows cnt=4 by 4 cycles; three paused cycles make it 7
    n_checks++;
    if (cycles !== 7) begin
      n_fail++;
      $display("FAIL pause_latency: got %0d cycles, expected 7", cycles);
    end
    chk("pause_done", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_abort();
    start(4'd5);
    tick(); tick(); tick();
    chk("abort_at2", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    pause = 1'b1; abort = 1'b1;
    tick();
    chk("abort_idle", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pause = 1'b0; abort = 1'b0;
    tick();
    chk("abort_no_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Abort held while IDLE does not block an accepted start
    abort = 1'b1;
    start(4'd3);
    chk("abort_idle_noeffect", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("abort_from_run", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    abort = 1'b0;
    tick();
  endtask

  task automatic test_load_err();
    start_valid = 1'b1; load_val = 4'd0;
    tick();
    chk("loaderr_pulse", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    load_val = 4'd15;
    tick();
    start_valid = 1'b0;
    chk("loaderr_then15", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    chk("run15_at1", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("run15_done", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    start_valid = 1'b1; load_val = 4'd2;
    tick();
    chk("b2b_first", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_cnt1", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_done", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_idle_gap", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    start_valid = 1'b0;
    chk("b2b_second", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
  endtask

  task automatic test_autoreload();
    reload_en = 1'b1;
    start(4'd3);
    tick(); tick(); tick();
    chk("reload_done1", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
`ifdef DCNT_AUTORELOAD_EN
    chk("reload_reloaded", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("reload_done2", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    reload_en = 1'b0;
    tick();
    chk("reload_stop", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    chk("reload_ignored", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    reload_en = 1'b0;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_abort();
    test_load_err();
    test_back_to_back();
    test_autoreload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dcnt_ctrl

`default_nettype wire
